// File: rtl/pipelined_bk_adder.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready handshake.
// S1 captures p/g, S2 holds the up-sweep result, S3 holds the down-sweep sum and flags.
module pipelined_bk_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int LOG = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 64 || (1 << LOG) != WIDTH) begin : g_bad_width
        $error("pipelined_bk_adder: WIDTH must be a power of two in 4..64");
    end

    logic             en;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
    logic             cin1_q, cin1_d;
    logic [WIDTH-1:0] p2_q, p2_d, gu2_q, gu2_d, pu2_q, pu2_d;
    logic             cin2_q, cin2_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [WIDTH:0]   carry;

    logic [LOG:0][WIDTH-1:0]   ug, up;
    logic [LOG-1:0][WIDTH-1:0] dg, dp;

    // Single stall condition: only a held output beat can stop the pipe.
    assign en       = !(v3_q && !out_ready);
    assign in_ready = en;

    // Up-sweep: at level l, node i (i+1 a multiple of 2^(l+1)) absorbs node i-2^l.
    assign ug[0] = g1_q;
    assign up[0] = p1_q;
    for (genvar l = 0; l < LOG; l++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (2 << l)) == 0) begin : g_node
                assign ug[l+1][i] = ug[l][i] | (up[l][i] & ug[l][i-(1<<l)]);
                assign up[l+1][i] = up[l][i] & up[l][i-(1<<l)];
            end else begin : g_pass
                assign ug[l+1][i] = ug[l][i];
                assign up[l+1][i] = up[l][i];
            end
        end
    end

    // Down-sweep fills in the remaining prefixes from the coarsest span back to the finest.
    assign dg[0] = gu2_q;
    assign dp[0] = pu2_q;
    for (genvar j = 0; j < LOG - 1; j++) begin : g_down
        localparam int L = LOG - 2 - j;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((((i + 1) % (2 << L)) == (1 << L)) && (i >= (2 << L))) begin : g_node
                assign dg[j+1][i] = dg[j][i] | (dp[j][i] & dg[j][i-(1<<L)]);
                assign dp[j+1][i] = dp[j][i] & dp[j][i-(1<<L)];
            end else begin : g_pass
                assign dg[j+1][i] = dg[j][i];
                assign dp[j+1][i] = dp[j][i];
            end
        end
    end

    always_comb begin
        bx     = sub ? ~b : b;
        p1_d   = a ^ bx;
        g1_d   = a & bx;
        cin1_d = cin;
        v1_d   = in_valid;

        p2_d   = p1_q;
        gu2_d  = ug[LOG];
        pu2_d  = up[LOG];
        cin2_d = cin1_q;
        v2_d   = v1_q;

        // Carry-in acts as a generate below bit 0 of every prefix span.
        carry  = {dg[LOG-1] | (dp[LOG-1] & {WIDTH{cin2_q}}), cin2_q};
        sum_d  = p2_q ^ carry[WIDTH-1:0];
        cout_d = carry[WIDTH];
        ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
        zero_d = ~|sum_d;
        v3_d   = v2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            p1_q   <= '0;
            g1_q   <= '0;
            cin1_q <= 1'b0;
            p2_q   <= '0;
            gu2_q  <= '0;
            pu2_q  <= '0;
            cin2_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            p1_q   <= p1_d;
            g1_q   <= g1_d;
            cin1_q <= cin1_d;
            p2_q   <= p2_d;
            gu2_q  <= gu2_d;
            pu2_q  <= pu2_d;
            cin2_q <= cin2_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v3_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_bk_adder.sv
// Runs WIDTH=4, 16 and 64 instances in lockstep on shared stimulus; each has its own scoreboard
// fed from an arithmetic reference model and drained by a single output monitor.
module tb_pipelined_bk_adder;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    localparam int unsigned WID [3] = '{4, 16, 64};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic [63:0] sum_w       [3];
    logic [2:0]  flags_w     [3];

    exp_t sb [3][$];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int W = (k == 0) ? 4 : (k == 1) ? 16 : 64;
        logic [W-1:0] s;
        logic         rdy, vld, co, ov, zr;
        pipelined_bk_adder #(.WIDTH(W)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy),
            .a(a[W-1:0]), .b(b[W-1:0]), .cin(cin), .sub(sub),
            .out_valid(vld), .out_ready(out_ready),
            .sum(s), .cout(co), .ovf(ov), .zero(zr)
        );
        assign in_ready_w[k]  = rdy;
        assign out_valid_w[k] = vld;
        assign sum_w[k]       = 64'(s);
        assign flags_w[k]     = {co, ov, zr};
    end

    function automatic exp_t model(input int unsigned w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic c, input logic s);
        logic [64:0] mask, full;
        logic [63:0] am, bm, r;
        exp_t e;
        mask = (65'd1 << w) - 65'd1;
        am   = av & mask[63:0];
        bm   = (s ? ~bv : bv) & mask[63:0];
        full = {1'b0, am} + {1'b0, bm} + {64'd0, c};
        r    = full[63:0] & mask[63:0];
        e.s  = r;
        e.c  = full[w];
        e.o  = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
        e.z  = (r == 64'd0);
        return e;
    endfunction

    task automatic check(input bit ok, input string name, input int k,
                         input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL w%0d %s: got %h, want %h at %0t", WID[k], name, act, req, $time);
        end
    endtask

    task automatic step(input bit v, input bit r, input logic [63:0] av, input logic [63:0] bv,
                        input bit c, input bit s, output bit acc);
        @(negedge clk);
        out_ready = r;
        in_valid  = v;
        a   = av;
        b   = bv;
        cin = c;
        sub = s;
        #1;
        acc = v && in_ready_w[1] && rst_n;
        if (acc)
            for (int k = 0; k < 3; k++) sb[k].push_back(model(WID[k], av, bv, c, s));
    endtask

    task automatic drain(input string name);
        bit acc;
        int unsigned n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 40) begin
            step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, acc);
            n++;
        end
        repeat (2) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, acc);
        for (int k = 0; k < 3; k++) check(sb[k].size() == 0, name, k, 64'(sb[k].size()), 0);
    endtask

    // Output monitor: handshake, stall-hold, reset-state and scoreboard checks.
    initial begin
        bit          prev_rst = 1'b0;
        bit          prev_stall [3] = '{1'b0, 1'b0, 1'b0};
        logic [63:0] prev_sum   [3];
        logic [2:0]  prev_flags [3];
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < 3; k++) begin
                if (rst_n && prev_rst) begin
                    check(out_valid_w[k] == 1'b0, "reset out_valid", k, 64'(out_valid_w[k]), 0);
                    check(sum_w[k] == 64'd0, "reset sum", k, sum_w[k], 0);
                    check(flags_w[k] == 3'b000, "reset cout/ovf/zero", k, 64'(flags_w[k]), 0);
                    check(in_ready_w[k] == 1'b1, "reset in_ready", k, 64'(in_ready_w[k]), 1);
                end
                if (rst_n) begin
                    check(in_ready_w[k] == !(out_valid_w[k] && !out_ready), "in_ready", k,
                          64'(in_ready_w[k]), 64'(!(out_valid_w[k] && !out_ready)));
                    if (prev_stall[k]) begin
                        check(out_valid_w[k] == 1'b1, "stall hold valid", k, 64'(out_valid_w[k]), 1);
                        check(sum_w[k] == prev_sum[k], "stall hold sum", k, sum_w[k], prev_sum[k]);
                        check(flags_w[k] == prev_flags[k], "stall hold flags", k,
                              64'(flags_w[k]), 64'(prev_flags[k]));
                    end
                    if (out_valid_w[k] && out_ready) begin
                        check(sb[k].size() != 0, "spurious beat", k, sum_w[k], 0);
                        if (sb[k].size() != 0) begin
                            e = sb[k].pop_front();
                            check(sum_w[k] == e.s, "sum", k, sum_w[k], e.s);
                            check(flags_w[k] == {e.c, e.o, e.z}, "cout/ovf/zero", k,
                                  64'(flags_w[k]), 64'({e.c, e.o, e.z}));
                        end
                    end
                end
                prev_stall[k] = rst_n && out_valid_w[k] && !out_ready;
                prev_sum[k]   = sum_w[k];
                prev_flags[k] = flags_w[k];
            end
            prev_rst = !rst_n;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] da [6] = '{64'h9999, 64'hFFFF, 64'h7FFF, 64'h0005, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] db [6] = '{64'h1000, 64'hFFFF, 64'h0001, 64'h0007, 64'h1234, 64'h0};
        bit          dc [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        bit          ds [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  bp_pat = 4'b1001;
        bit          acc;
        int unsigned n, cyc;

        // Reset with a beat offered the whole time; none may be accepted.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 64'h1;
        b        = 64'h2;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (5) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, acc);

        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, da[i], db[i], dc[i], ds[i], acc);
        drain("directed drain");

        // Back-to-back beats against a 1,0,0,1 out_ready pattern.
        n   = 0;
        cyc = 0;
        while (n < 10 && cyc < 100) begin
            step(1'b1, bp_pat[cyc % 4], {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom), 1'($urandom), acc);
            if (acc) n++;
            cyc++;
        end
        check(n == 10, "backpressure beats accepted", 1, 64'(n), 10);
        drain("backpressure drain");

        // Three beats in flight, then a one-cycle reset must discard them all.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'($urandom), acc);
        @(negedge clk);
        rst_n     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) sb[k].delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (8) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, acc);

        // Random regression with random valid and out_ready.
        n   = 0;
        cyc = 0;
        while (n < 10000 && cyc < 60000) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                 {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), acc);
            if (acc) n++;
            cyc++;
        end
        check(n == 10000, "random beats accepted", 1, 64'(n), 10000);
        drain("random drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipelined_bk_adder.md
PIPELINED_BK_ADDER -- requirements
Module: pipelined_bk_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a power of two in 4..64, any other value SHALL cause an elaboration error.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  an operand beat is presented.
REQ-005 in_ready  output  1  the block accepts the beat this cycle.
REQ-006 a, b  input  WIDTH  operands.
REQ-007 cin  input  1  carry-in.
REQ-008 sub  input  1  0 = a+b+cin; 1 = a+~b+cin (a-b when cin=1).
REQ-009 out_valid  output  1  result beat is valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1 (1 = no borrow when sub=1).
REQ-013 ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
REQ-014 zero  output  1  sum == 0.

Function
REQ-015 The carry network SHALL be a Brent-Kung parallel prefix over (g,p), with 2*log2(WIDTH)-1 prefix levels.
REQ-016 The datapath SHALL have three register stages: S1 = operand capture (p, g, cin, with b inverted when sub=1); S2 = after the up-sweep; S3 = after the down-sweep, sum XOR and flags.
REQ-017 A beat is accepted when in_valid && in_ready; an unstalled beat SHALL appear on out_valid exactly 3 cycles after acceptance.
REQ-018 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-019 Global enable en = !(out_valid && !out_ready); in_ready SHALL equal en, and it SHALL be combinational from out_ready and out_valid only.
REQ-020 When en=0, all stage registers, valid bits and outputs SHALL hold their values.
REQ-021 A result beat completes when out_valid && out_ready.
REQ-022 Per-stage valid bits SHALL advance only when en=1; empty stages (bubbles) SHALL advance without creating spurious out_valid.
REQ-023 When out_valid=0, the values of sum, cout, ovf and zero are don't-care, but they SHALL be stable (registered, glitch-free).
REQ-024 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-025 sub and cin SHALL be sampled per beat; a mode change between consecutive beats SHALL need no idle cycle.
REQ-026 Results SHALL equal {cout,sum} = a + (sub ? ~b : b) + cin, computed at WIDTH+1 bits.

Reset
REQ-027 While rst_n=0 at a clock edge, all stage valid bits and out_valid SHALL clear to 0, and sum, cout, ovf and zero SHALL clear to 0.
REQ-028 After reset, zero SHALL read 0, not 1.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n rises.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight beats, and no discarded beat SHALL ever appear on the output.
REQ-031 A beat presented in the same cycle that rst_n=0 SHALL NOT be accepted.

Verification (WIDTH=16 unless stated)
REQ-032 a=9999h, b=1000h, cin=1, sub=0 -> 3 cycles later: sum=A99Ah, cout=0, ovf=0, zero=0.
REQ-033 a=FFFFh, b=FFFFh, cin=1 -> sum=FFFFh, cout=1, ovf=0; a=7FFFh, b=0001h, cin=0 -> sum=8000h, ovf=1, cout=0.
REQ-034 sub=1, cin=1, a=0005h, b=0007h -> sum=FFFEh, cout=0, ovf=0; then a=b=1234h -> sum=0000h, zero=1, cout=1.
REQ-035 Backpressure: stream 10 back-to-back beats while out_ready toggles 1,0,0,1,... -> in_ready mirrors the stall, outputs hold during stalls, and all 10 results emerge in order and match a reference model.
REQ-036 Drive rst_n=0 for one cycle with 3 beats in flight -> out_valid=0 from the next cycle, and none of the 3 results ever appears.
REQ-037 Random regression at WIDTH=4, 16 and 64, 10k beats each with random out_ready -> every result matches REQ-026 and the flag definitions in REQ-013 and REQ-014.
